// File: rtl/writeback_unit.sv
// Writeback stage: retires ALU results immediately and completes loads once the
// data-memory response arrives, driving the register file write port.
module writeback_unit #(
  parameter int TIMEOUT_CYCLES = 16,
  parameter int CNT_W          = 8
) (
  input  logic        clock,
  input  logic        reset_n,
  input  logic        ex_valid,
  output logic        ex_ready,
  input  logic [4:0]  ex_rd,
  input  logic [31:0] ex_result,
  input  logic        ex_is_load,
  input  logic [2:0]  ex_funct3,
  input  logic [1:0]  ex_addr_low,
  input  logic        mem_rvalid,
  input  logic [31:0] mem_rdata,
  output logic [4:0]  rd,
  output logic [31:0] data,
  output logic        reg_write,
  output logic        load_pending,
  output logic [4:0]  pending_rd,
  input  logic        error_clear,
  output logic        error
);

  typedef enum logic {IDLE, WAIT_MEM} state_t;

  localparam logic [CNT_W-1:0] TMO_VAL = CNT_W'(TIMEOUT_CYCLES);

  state_t            state, state_next;
  logic [CNT_W-1:0]  counter, counter_next, counter_inc;
  logic [2:0]        ld_funct3, ld_funct3_next;
  logic [1:0]        ld_addr, ld_addr_next;
  logic [4:0]        rd_next, pending_rd_next;
  logic [31:0]       data_next, load_value;
  logic              reg_write_next, load_pending_next, error_next;
  logic              fault, ld_fault, timeout_hit;
  logic [7:0]        sel_byte;
  logic [15:0]       sel_half;

  assign counter_inc = counter + 1'b1;
  assign timeout_hit = (state == WAIT_MEM) && !mem_rvalid && (counter_inc == TMO_VAL);
  assign ex_ready    = (state == IDLE);

  assign sel_byte = mem_rdata[{ld_addr, 3'b000} +: 8];
  assign sel_half = mem_rdata[{ld_addr[1], 4'b0000} +: 16];

  // Alignment and funct3 legality are judged when the response arrives.
  always_comb begin
    ld_fault   = 1'b0;
    load_value = mem_rdata;
    case (ld_funct3)
      3'd0:    load_value = {{24{sel_byte[7]}}, sel_byte};
      3'd4:    load_value = {24'd0, sel_byte};
      3'd1: begin
        load_value = {{16{sel_half[15]}}, sel_half};
        ld_fault   = ld_addr[0];
      end
      3'd5: begin
        load_value = {16'd0, sel_half};
        ld_fault   = ld_addr[0];
      end
      3'd2:    ld_fault = (ld_addr != 2'd0);
      default: ld_fault = 1'b1;
    endcase
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:     if (ex_valid && ex_is_load) state_next = WAIT_MEM;
      WAIT_MEM: if (mem_rvalid || timeout_hit) state_next = IDLE;
      default:  state_next = IDLE;
    endcase
  end

  always_comb begin
    rd_next           = rd;
    data_next         = data;
    reg_write_next    = 1'b0;
    pending_rd_next   = pending_rd;
    ld_funct3_next    = ld_funct3;
    ld_addr_next      = ld_addr;
    counter_next      = counter;
    fault             = 1'b0;
    load_pending_next = (state_next == WAIT_MEM);
    case (state)
      IDLE: begin
        fault = mem_rvalid;
        if (ex_valid) begin
          if (ex_is_load) begin
            pending_rd_next = ex_rd;
            ld_funct3_next  = ex_funct3;
            ld_addr_next    = ex_addr_low;
            counter_next    = '0;
          end else if (ex_rd != 5'd0) begin
            rd_next        = ex_rd;
            data_next      = ex_result;
            reg_write_next = 1'b1;
          end
        end
      end
      WAIT_MEM: begin
        if (mem_rvalid) begin
          if (ld_fault) begin
            fault = 1'b1;
          end else if (pending_rd != 5'd0) begin
            rd_next        = pending_rd;
            data_next      = load_value;
            reg_write_next = 1'b1;
          end
        end else if (timeout_hit) begin
          fault = 1'b1;
        end else begin
          counter_next = counter_inc;
        end
      end
      default: ;
    endcase
    error_next = error_clear ? 1'b0 : (error | fault);
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      rd           <= '0;
      data         <= '0;
      reg_write    <= 1'b0;
      load_pending <= 1'b0;
      pending_rd   <= '0;
      error        <= 1'b0;
      counter      <= '0;
      ld_funct3    <= '0;
      ld_addr      <= '0;
    end else begin
      rd           <= rd_next;
      data         <= data_next;
      reg_write    <= reg_write_next;
      load_pending <= load_pending_next;
      pending_rd   <= pending_rd_next;
      error        <= error_next;
      counter      <= counter_next;
      ld_funct3    <= ld_funct3_next;
      ld_addr      <= ld_addr_next;
    end
  end

endmodule

// File: tb/tb_writeback_unit.sv
// Scoreboarded random/directed bench for writeback_unit; expected writes are
// queued with their due cycle and matched by an independent monitor.
module tb_writeback_unit;

  localparam int TMO = 4;

  logic        clock = 1'b0;
  logic        reset_n;
  logic        ex_valid, ex_ready, ex_is_load, mem_rvalid, error_clear;
  logic [4:0]  ex_rd, rd, pending_rd;
  logic [31:0] ex_result, mem_rdata, data;
  logic [2:0]  ex_funct3;
  logic [1:0]  ex_addr_low;
  logic        reg_write, load_pending, error;

  writeback_unit #(.TIMEOUT_CYCLES(TMO), .CNT_W(8)) dut (
    .clock(clock), .reset_n(reset_n),
    .ex_valid(ex_valid), .ex_ready(ex_ready), .ex_rd(ex_rd), .ex_result(ex_result),
    .ex_is_load(ex_is_load), .ex_funct3(ex_funct3), .ex_addr_low(ex_addr_low),
    .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata),
    .rd(rd), .data(data), .reg_write(reg_write),
    .load_pending(load_pending), .pending_rd(pending_rd),
    .error_clear(error_clear), .error(error)
  );

  always #5 clock = ~clock;

  typedef struct {
    logic [4:0]  rd;
    logic [31:0] data;
    int          due;
  } wr_t;

  wr_t exp_q[$];
  int  checks = 0;
  int  passes = 0;
  int  cyc = 0;
  bit  exp_err = 1'b0;

  always @(posedge clock) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act === exp) passes++;
    else $display("FAIL %s: got %h, expected %h", name, act, exp);
  endtask

  // Reference load semantics straight from the ISA rules.
  function automatic void ref_load(input logic [2:0] f3, input logic [1:0] a,
                                   input logic [31:0] w, output bit ok, output logic [31:0] v);
    int sh;
    logic [31:0] b, h;
    sh = 8 * int'(a);
    b  = (w >> sh) % 256;
    h  = (w >> sh) % 65536;
    ok = 1'b1;
    v  = 32'd0;
    case (f3)
      3'd0: v = (b >= 128) ? b - 256 : b;
      3'd4: v = b;
      3'd1: begin ok = (a % 2 == 0); v = (h >= 32768) ? h - 65536 : h; end
      3'd5: begin ok = (a % 2 == 0); v = h; end
      3'd2: begin ok = (a == 0); v = w; end
      default: ok = 1'b0;
    endcase
  endfunction

  // Monitor: every register-file write must match the oldest expectation on its due cycle.
  always @(negedge clock) begin
    if (reset_n === 1'b1) begin
      while (exp_q.size() > 0 && exp_q[0].due < cyc) begin
        checks++;
        $display("FAIL missed_write: got no write, expected rd=%0d data=%h at cycle %0d",
                 exp_q[0].rd, exp_q[0].data, exp_q[0].due);
        void'(exp_q.pop_front());
      end
      if (reg_write === 1'b1) begin
        if (exp_q.size() == 0) begin
          checks++;
          $display("FAIL unexpected_write: got rd=%0d data=%h, expected no write", rd, data);
        end else begin
          wr_t e;
          e = exp_q.pop_front();
          chk("wb_cycle", cyc, e.due);
          chk("wb_rd", {27'd0, rd}, {27'd0, e.rd});
          chk("wb_data", data, e.data);
        end
      end
    end
  end

  task automatic drive_idle();
    ex_valid    = 1'b0;
    ex_is_load  = 1'b0;
    mem_rvalid  = 1'b0;
    error_clear = 1'b0;
    ex_rd       = 5'($urandom);
    ex_result   = $urandom;
    ex_funct3   = 3'($urandom);
    ex_addr_low = 2'($urandom);
    mem_rdata   = $urandom;
  endtask

  task automatic alu(input logic [4:0] r, input logic [31:0] v);
    @(negedge clock);
    chk("alu_ready", {31'd0, ex_ready}, 32'd1);
    chk("alu_error", {31'd0, error}, {31'd0, exp_err});
    drive_idle();
    ex_valid  = 1'b1;
    ex_rd     = r;
    ex_result = v;
    if (r != 5'd0) exp_q.push_back('{rd: r, data: v, due: cyc + 1});
  endtask

  task automatic load(input logic [4:0] r, input logic [2:0] f3, input logic [1:0] a,
                      input int lat, input logic [31:0] w);
    int n_wait;
    bit ok;
    logic [31:0] v;
    @(negedge clock);
    chk("ld_ready", {31'd0, ex_ready}, 32'd1);
    drive_idle();
    ex_valid    = 1'b1;
    ex_is_load  = 1'b1;
    ex_rd       = r;
    ex_funct3   = f3;
    ex_addr_low = a;
    n_wait = (lat >= TMO) ? TMO : lat;
    for (int i = 0; i < n_wait; i++) begin
      @(negedge clock);
      drive_idle();
      chk("wait_ready", {31'd0, ex_ready}, 32'd0);
      chk("wait_pending", {31'd0, load_pending}, 32'd1);
      chk("wait_pending_rd", {27'd0, pending_rd}, {27'd0, r});
    end
    if (lat < TMO) begin
      @(negedge clock);
      chk("resp_pending", {31'd0, load_pending}, 32'd1);
      drive_idle();
      mem_rvalid = 1'b1;
      mem_rdata  = w;
      ref_load(f3, a, w, ok, v);
      if (!ok) exp_err = 1'b1;
      else if (r != 5'd0) exp_q.push_back('{rd: r, data: v, due: cyc + 1});
    end else begin
      exp_err = 1'b1;
    end
    @(negedge clock);
    drive_idle();
    chk("done_ready", {31'd0, ex_ready}, 32'd1);
    chk("done_pending", {31'd0, load_pending}, 32'd0);
    chk("done_error", {31'd0, error}, {31'd0, exp_err});
  endtask

  task automatic spurious(input bit clr);
    @(negedge clock);
    drive_idle();
    mem_rvalid  = 1'b1;
    error_clear = clr;
    @(negedge clock);
    drive_idle();
    exp_err = clr ? 1'b0 : 1'b1;
    chk("spurious_error", {31'd0, error}, {31'd0, exp_err});
  endtask

  task automatic clear_err();
    @(negedge clock);
    drive_idle();
    error_clear = 1'b1;
    @(negedge clock);
    drive_idle();
    exp_err = 1'b0;
    chk("clear_error", {31'd0, error}, 32'd0);
  endtask

  initial begin
    reset_n = 1'b0;
    drive_idle();
    repeat (2) @(negedge clock);
    chk("rst_rd", {27'd0, rd}, 32'd0);
    chk("rst_data", data, 32'd0);
    chk("rst_reg_write", {31'd0, reg_write}, 32'd0);
    chk("rst_pending", {31'd0, load_pending}, 32'd0);
    chk("rst_pending_rd", {27'd0, pending_rd}, 32'd0);
    chk("rst_error", {31'd0, error}, 32'd0);
    chk("rst_ready", {31'd0, ex_ready}, 32'd1);
    reset_n = 1'b1;

    alu(5'd5, 32'hDEADBEEF);
    alu(5'd6, 32'h12345678);
    @(negedge clock);
    drive_idle();
    chk("b2b_data", data, 32'h12345678);

    load(5'd7, 3'd0, 2'd3, 1, 32'h80FF_0000);
    chk("lb_value", data, 32'hFFFF_FF80);
    load(5'd8, 3'd5, 2'd2, 0, 32'h8001_1234);
    chk("lhu_value", data, 32'h0000_8001);
    load(5'd9, 3'd2, 2'd0, TMO - 1, 32'hCAFE_F00D);
    chk("lw_edge_value", data, 32'hCAFE_F00D);
    chk("lw_edge_error", {31'd0, error}, 32'd0);

    load(5'd10, 3'd2, 2'd1, 1, 32'h1111_2222);
    clear_err();
    spurious(1'b0);
    clear_err();
    spurious(1'b1);
    load(5'd11, 3'd2, 2'd0, TMO, 32'h0);
    clear_err();
    load(5'd12, 3'd3, 2'd0, 0, 32'h5555_AAAA);
    clear_err();

    alu(5'd0, 32'hFFFF_FFFF);
    load(5'd0, 3'd2, 2'd0, 1, 32'h7777_7777);

    // Asynchronous reset while a load is outstanding.
    load(5'd13, 3'd2, 2'd0, TMO, 32'h0);
    clear_err();
    @(negedge clock);
    drive_idle();
    ex_valid = 1'b1; ex_is_load = 1'b1; ex_rd = 5'd14; ex_funct3 = 3'd2; ex_addr_low = 2'd0;
    @(negedge clock);
    drive_idle();
    chk("pre_rst_pending", {31'd0, load_pending}, 32'd1);
    #2 reset_n = 1'b0;
    #1;
    chk("arst_pending", {31'd0, load_pending}, 32'd0);
    chk("arst_pending_rd", {27'd0, pending_rd}, 32'd0);
    chk("arst_rd", {27'd0, rd}, 32'd0);
    chk("arst_data", data, 32'd0);
    chk("arst_ready", {31'd0, ex_ready}, 32'd1);
    @(negedge clock);
    reset_n = 1'b1;
    exp_err = 1'b0;
    spurious(1'b0);
    clear_err();

    for (int n = 0; n < 250; n++) begin
      int op;
      op = $urandom_range(0, 9);
      if (op <= 4) alu(5'($urandom), $urandom);
      else if (op <= 8) load(5'($urandom), 3'($urandom), 2'($urandom), $urandom_range(0, 5), $urandom);
      else if ($urandom_range(0, 1) == 0) spurious(1'($urandom));
      else clear_err();
    end

    repeat (3) @(negedge clock);
    chk("queue_drained", exp_q.size(), 32'd0);
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
